// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame widths, read command code and master state encoding
package spi_pkg;
  localparam int CMD_W = 8;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int FRAME_W = 64;
  localparam logic [CMD_W-1:0] CMD_READ = 8'hFF;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: CLK_DIV sck divider; ports clk, rst (async low), en in; sck, rise_pulse/fall_pulse (high in the cycle before sck rises/falls) out
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise_pulse,
  output logic fall_pulse
);
  logic [7:0] cnt;
  logic tick;
  assign tick = en && cnt == 8'(CLK_DIV - 1);
  assign rise_pulse = tick && !sck;
  assign fall_pulse = tick && sck;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= !sck;
    end else begin
      cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master for 64-bit cmd/addr/wdata frames; ports clk, rst (async low), start, cmd, addr, wdata, miso in; busy, done, rdata, cs, sck, mosi out
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);
  localparam logic [11:0] HOLD_END = 12'(CLK_DIV - 1);
  localparam logic [11:0] GAP_END = 12'(CS_GAP * CLK_DIV - 1);
  state_t state, state_n;
  logic [FRAME_W-1:0] shreg;
  logic [DATA_W-1:0] rshift;
  logic [5:0] bit_cnt;
  logic [11:0] tmr;
  logic rise, fall, clk_en;
  assign clk_en = state == SETUP || state == XFER;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk(clk),
    .rst(rst),
    .en(clk_en),
    .sck(sck),
    .rise_pulse(rise),
    .fall_pulse(fall)
  );
  assign busy = state != IDLE;
  assign cs = !(state == SETUP || state == XFER || state == HOLD);
  assign mosi = clk_en && shreg[FRAME_W-1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SETUP : IDLE;
      SETUP:   state_n = rise ? XFER : SETUP;
      XFER:    state_n = fall && bit_cnt == 6'd63 ? HOLD : XFER;
      HOLD:    state_n = tmr == HOLD_END ? GAP : HOLD;
      GAP:     state_n = tmr == GAP_END ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shreg <= '0;
      rshift <= '0;
      rdata <= '0;
      bit_cnt <= '0;
      tmr <= '0;
      done <= 1'b0;
    end else begin
      done <= state == HOLD && state_n == GAP;
      tmr <= state == state_n ? tmr + 12'd1 : 12'd0;
      if (state == IDLE && start) begin
        shreg <= {cmd, addr, wdata};
        bit_cnt <= '0;
      end else if (fall && bit_cnt != 6'd63) begin
        shreg <= {shreg[FRAME_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (rise && bit_cnt[5]) rshift <= {rshift[DATA_W-2:0], miso};
      if (state == HOLD && state_n == GAP) rdata <= rshift;
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: random and directed frames on two spi_master configurations checked every cycle against a timing-arithmetic model
module tb_spi_master;
  localparam int DA = 4, GA = 2, DB = 2, GB = 1;
  logic clk = 1'b0, rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b1, miso_a = 1'b0, miso_b = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [23:0] addr_a = '0, addr_b = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;
  logic busy_a, done_a, cs_a, sck_a, mosi_a, busy_b, done_b, cs_b, sck_b, mosi_b;
  logic [31:0] rdata_a, rdata_b;
  int checks = 0, errors = 0, cyc = 0, ts = 0;
  int t0 [2];
  bit act [2] = '{1'b0, 1'b0};
  logic [63:0] fr [2], mp [2];
  logic [31:0] er [2] = '{32'h0, 32'h0};
  int dv [2] = '{DA, DB};
  int gv [2] = '{GA, GB};
  logic fix_on = 1'b0;
  logic [63:0] fix_mp = '0;
  logic pcs_a = 1'b1, psck_a = 1'b0, pbusy_a = 1'b0, pcs_b = 1'b1;
  int t_csf, t_r1, t_lf, t_dn, t_bf, n_dn, n_r, t_rise_b;
  bit have_rise_b = 1'b0;
  logic [63:0] mcap;

  spi_master #(.CLK_DIV(DA), .CS_GAP(GA)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .cmd(cmd_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .done(done_a), .rdata(rdata_a), .cs(cs_a), .sck(sck_a), .mosi(mosi_a), .miso(miso_a)
  );
  spi_master #(.CLK_DIV(DB), .CS_GAP(GB)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .cmd(cmd_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .cs(cs_b), .sck(sck_b), .mosi(mosi_b), .miso(miso_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    cmd_b = 8'($urandom);
    addr_b = 24'($urandom);
    wdata_b = $urandom;
  end

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic step(input int i, input logic st, input logic [63:0] in_fr, input logic [4:0] got,
                      input logic [31:0] got_rd, output logic m);
    int d, dd, hs, dn, en, b;
    logic [4:0] e;
    dd = dv[i];
    hs = 1 + 128 * dd;
    dn = 1 + 129 * dd;
    en = dn + gv[i] * dd;
    if (!rst) begin
      act[i] = 1'b0;
      er[i] = '0;
    end
    d = act[i] ? cyc - t0[i] : -1;
    if (d >= en) begin
      act[i] = 1'b0;
      d = -1;
    end
    b = (d >= 1 && d < hs) ? (d - 1) / (2 * dd) : 0;
    if (d == dn) er[i] = mp[i][31:0];
    e[4] = !(d >= 1 && d < dn);
    e[3] = d >= 1 + dd && d < hs && ((d - 1 - dd) / dd) % 2 == 0;
    e[2] = d >= 1 && d < hs && fr[i][63-b];
    e[1] = d >= 1 && d < en;
    e[0] = d == dn;
    cmp(i == 0 ? "a cs/sck/mosi/busy/done" : "b cs/sck/mosi/busy/done", 64'(got), 64'(e));
    cmp(i == 0 ? "a rdata" : "b rdata", 64'(got_rd), 64'(er[i]));
    if (rst && d < 0 && st) begin
      act[i] = 1'b1;
      t0[i] = cyc;
      fr[i] = in_fr;
      mp[i] = (i == 0 && fix_on) ? fix_mp : {$urandom, $urandom};
    end
    m = (d >= 1 && d < hs) ? mp[i][63-b] : 1'($urandom);
  endtask

  always @(negedge clk) begin
    step(0, start_a, {cmd_a, addr_a, wdata_a}, {cs_a, sck_a, mosi_a, busy_a, done_a}, rdata_a, miso_a);
    step(1, start_b, {cmd_b, addr_b, wdata_b}, {cs_b, sck_b, mosi_b, busy_b, done_b}, rdata_b, miso_b);
    if (pcs_a && !cs_a) begin
      t_csf = cyc; t_r1 = -1; t_dn = -1; t_bf = -1; n_dn = 0; n_r = 0;
    end
    if (!psck_a && sck_a) begin
      if (n_r == 0) t_r1 = cyc;
      n_r++;
      mcap = {mcap[62:0], mosi_a};
    end
    if (psck_a && !sck_a) t_lf = cyc;
    if (done_a) begin
      n_dn++;
      t_dn = cyc;
    end
    if (pbusy_a && !busy_a) t_bf = cyc;
    if (!rst) have_rise_b = 1'b0;
    else if (!pcs_b && cs_b) begin
      cmp("b done with cs rise", 64'(done_b), 64'd1);
      t_rise_b = cyc;
      have_rise_b = 1'b1;
    end else if (pcs_b && !cs_b && have_rise_b) begin
      cmp("b cs high cycles", 64'(cyc - t_rise_b), 64'(GB * DB + 1));
    end
    pcs_a = cs_a; psck_a = sck_a; pbusy_a = busy_a; pcs_b = cs_b;
  end

  task automatic launch(input logic [7:0] c, input logic [23:0] a, input logic [31:0] w);
    @(posedge clk); #1;
    cmd_a = c; addr_a = a; wdata_a = w; start_a = 1'b1; ts = cyc;
    @(posedge clk); #1;
    start_a = 1'b0; cmd_a = 8'($urandom); addr_a = 24'($urandom); wdata_a = $urandom;
  endtask

  task automatic finish_a;
    for (int k = 0; k < 3000 && busy_a; k++) @(negedge clk);
    cmp("a busy timeout", 64'(busy_a), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 60000", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    cmp("reset cs", 64'(cs_a), 64'd1);
    cmp("reset sck/mosi/busy/done", 64'({sck_a, mosi_a, busy_a, done_a}), 64'd0);
    cmp("reset rdata", 64'(rdata_a), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    launch(8'h02, 24'h123456, 32'hDEADBEEF);
    repeat (99) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    finish_a();
    cmp("w cs fall", 64'(t_csf - ts), 64'd1);
    cmp("w first rise", 64'(t_r1 - ts), 64'd5);
    cmp("w last fall", 64'(t_lf - ts), 64'd513);
    cmp("w done", 64'(t_dn - ts), 64'd517);
    cmp("w busy fall", 64'(t_bf - ts), 64'd525);
    cmp("w rise count", 64'(n_r), 64'd64);
    cmp("w done count", 64'(n_dn), 64'd1);
    cmp("w mosi bits", mcap, 64'h02123456DEADBEEF);
    fix_on = 1'b1;
    fix_mp = {$urandom, 32'hA5C30F96};
    launch(8'hFF, 24'($urandom), $urandom);
    finish_a();
    cmp("read rdata", 64'(rdata_a), 64'hA5C30F96);
    fix_mp = {32'hFFFFFFFF, 32'h0};
    launch(8'h5A, 24'($urandom), $urandom);
    finish_a();
    cmp("write stuck miso rdata", 64'(rdata_a), 64'd0);
    fix_on = 1'b0;
    launch(8'h03, 24'($urandom), $urandom);
    repeat (199) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("abort cs", 64'(cs_a), 64'd1);
    cmp("abort sck/busy", 64'({sck_a, busy_a}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cmp("abort done count", 64'(n_dn), 64'd0);
    fix_on = 1'b1;
    fix_mp = {$urandom, 32'h0F1E2D3C};
    launch(8'hFF, 24'hABCDEF, 32'h01234567);
    finish_a();
    fix_on = 1'b0;
    cmp("post-reset rdata", 64'(rdata_a), 64'h0F1E2D3C);
    cmp("post-reset done", 64'(t_dn - ts), 64'd517);
    cmp("post-reset done count", 64'(n_dn), 64'd1);
    for (int n = 0; n < 5; n++) begin
      launch($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom), 24'($urandom), $urandom);
      finish_a();
      cmp("rand done count", 64'(n_dn), 64'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
